// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Collects a 3-byte command frame from the UART receiver (operand A, operand B,
//   opcode). It drives the captured fields into a combinational ALU, captures
//   the result, and requests a single transmit of the result byte.
//   A partial frame is discarded if the next byte does not arrive in time.
//   A byte that arrives while a result is still in flight is dropped and
//   flagged as an overrun.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   i_rx_done       receiver byte-valid flag (rising edge = new byte)
//   i_rx_data       received byte, valid with the i_rx_done rising edge
//   i_alu_result    combinational ALU output for o_alu_a/o_alu_b/o_alu_op
//   i_tx_done       transmitter finished (rising edge = done)
//   o_alu_a/b/op    registered frame fields
//   o_tx_start      one-cycle transmit request
//   o_tx_data       registered result byte, stable until the transmit completes
//   o_busy          high from opcode capture until the transmit completes
//   o_timeout       one-cycle pulse when a partial frame is discarded
//   o_overrun       sticky; a byte arrived while busy
//
// state   | meaning
// --------+--------------------------------------------------
// WAIT_A  | idle, waiting for operand A
// WAIT_B  | operand A held, waiting for operand B (timed)
// WAIT_OP | operands held, waiting for opcode (timed)
// EXEC    | ALU settling on stable operands; result captured
// SEND    | o_tx_start asserted for this single cycle
// WAIT_TX | waiting for the transmitter to finish

module uart_cmd_parser #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_done_q;
    logic                  tx_done_q;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;

    logic rx_evt;
    logic tx_evt;

    // History regs reset to 0, so a done flag already high out of reset
    // is seen as a fresh edge.
    assign rx_evt = i_rx_done & ~rx_done_q;
    assign tx_evt = i_tx_done & ~tx_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT_A;
            rx_done_q <= 1'b0;
            tx_done_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= i_rx_done;
            tx_done_q <= i_tx_done;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            S_WAIT_A: begin
                if (rx_evt) begin
                    alu_a_d = i_rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // An arriving byte beats the timeout on the terminal cycle.
                if (rx_evt) begin
                    alu_b_d = i_rx_data;
                    state_d = S_WAIT_OP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (rx_evt) begin
                    alu_op_d = i_rx_data[OP_WIDTH-1:0];
                    state_d  = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = S_SEND;
                if (rx_evt) overrun_d = 1'b1;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
                if (rx_evt) overrun_d = 1'b1;
            end
            S_WAIT_TX: begin
                if (tx_evt) state_d = S_WAIT_A;
                if (rx_evt) overrun_d = 1'b1;
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == S_SEND);
    assign o_busy     = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a 16-cycle inter-byte timeout and an
// A+B stand-in ALU.

module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_timeout;
    logic       o_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int tx_cnt  = 0;
    int to_cnt  = 0;
    logic [7:0] last_tx_data = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .DATA_WIDTH    (8),
        .OP_WIDTH      (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_overrun   (o_overrun)
    );

    // Stand-in ALU: always adds the operands.
    assign i_alu_result = o_alu_a + o_alu_b;

    always @(negedge clk) begin
        if (o_tx_start) begin
            tx_cnt       <= tx_cnt + 1;
            last_tx_data <= o_tx_data;
        end
        if (o_timeout) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge; all driving and checking
    // happens here, clear of both clock edges and of the monitor.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        step();
        i_rx_data = d;
        i_rx_done = 1'b1;
        repeat (hold) step();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx();
        step();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},       o_alu_a,    0);
        check({tag, "_b"},       o_alu_b,    0);
        check({tag, "_op"},      o_alu_op,   0);
        check({tag, "_txdata"},  o_tx_data,  0);
        check({tag, "_txstart"}, o_tx_start, 0);
        check({tag, "_busy"},    o_busy,     0);
        check({tag, "_timeout"}, o_timeout,  0);
        check({tag, "_overrun"}, o_overrun,  0);
    endtask

    // Sends a frame and waits (bounded) for the transmit request; finishes the
    // transmit handshake only when do_tx is set.
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int hold, input logic [7:0] exp_res,
                         input bit do_tx);
        int start = tx_cnt;
        send_byte(a, hold);
        send_byte(b, hold);
        send_byte(op, hold);
        for (int i = 0; i < 10 && tx_cnt == start; i++) step();
        check({tag, "_txcount"}, tx_cnt - start, 1);
        check({tag, "_a"},       o_alu_a,  a);
        check({tag, "_b"},       o_alu_b,  b);
        check({tag, "_op"},      o_alu_op, op & 8'h3F);
        check({tag, "_result"},  last_tx_data, exp_res);
        check({tag, "_busy"},    o_busy,   1);
        if (do_tx) begin
            pulse_tx();
            check({tag, "_idle"}, o_busy, 0);
        end
    endtask

    initial begin
        int snap;
        reset     = 1'b1;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_tx_done = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;

        // Normal frame with exact latency.
        send_byte(8'h05, 1);
        send_byte(8'h03, 1);
        send_byte(8'h20, 1);
        check("norm_a",       o_alu_a,    8'h05);
        check("norm_b",       o_alu_b,    8'h03);
        check("norm_op",      o_alu_op,   6'h20);
        check("norm_busy",    o_busy,     1);
        check("norm_start0",  o_tx_start, 0);
        step();
        check("norm_start1",  o_tx_start, 1);
        check("norm_txdata",  o_tx_data,  8'h08);
        step();
        check("norm_start2",  o_tx_start, 0);
        check("norm_busy_tx", o_busy,     1);
        pulse_tx();
        check("norm_idle",    o_busy,     0);
        check("norm_txcount", tx_cnt,     1);

        // Held done flag; opcode byte upper bits must be stripped.
        frame("held", 8'h05, 8'h03, 8'hE0, 12, 8'h08, 1'b1);
        check("held_overrun", o_overrun, 0);
        check("held_timeout", to_cnt,    0);

        // Timeout after operand A.
        send_byte(8'h11, 1);
        repeat (15) step();
        check("to_early",     o_timeout, 0);
        step();
        check("to_pulse",     o_timeout, 1);
        step();
        check("to_pulse_end", o_timeout, 0);
        check("to_count",     to_cnt,    1);
        check("to_keep_a",    o_alu_a,   8'h11);
        frame("after_to", 8'h01, 8'h02, 8'h20, 1, 8'h03, 1'b1);

        // Operand B lands on the terminal count cycle.
        send_byte(8'h22, 1);
        repeat (14) step();
        send_byte(8'h33, 1);
        check("bound_b",      o_alu_b, 8'h33);
        send_byte(8'h20, 1);
        repeat (3) step();
        check("bound_timeout", to_cnt,  1);
        check("bound_result",  last_tx_data, 8'h55);
        pulse_tx();
        check("bound_idle",    o_busy, 0);

        // Overrun during WAIT_TX.
        frame("ovr", 8'h0A, 8'h0B, 8'h20, 1, 8'h15, 1'b0);
        step();
        send_byte(8'hAA, 1);
        check("ovr_flag",  o_overrun, 1);
        check("ovr_a",     o_alu_a,   8'h0A);
        check("ovr_busy",  o_busy,    1);
        pulse_tx();
        check("ovr_idle",  o_busy,    0);
        frame("post_ovr", 8'h04, 8'h06, 8'h20, 1, 8'h0A, 1'b1);
        check("ovr_sticky", o_overrun, 1);

        // Reset in WAIT_OP.
        send_byte(8'h07, 1);
        send_byte(8'h08, 1);
        snap  = tx_cnt;
        reset = 1'b1;
        step();
        check_all_zero("rst_op");
        reset = 1'b0;
        repeat (5) step();
        check("rst_op_nostart", tx_cnt - snap, 0);
        frame("post_rst_op", 8'h02, 8'h03, 8'h20, 1, 8'h05, 1'b1);

        // Reset in WAIT_TX.
        frame("pre_rst_tx", 8'h10, 8'h20, 8'h20, 1, 8'h30, 1'b0);
        step();
        snap  = tx_cnt;
        reset = 1'b1;
        step();
        check_all_zero("rst_tx");
        reset = 1'b0;
        repeat (5) step();
        check("rst_tx_nostart", tx_cnt - snap, 0);
        frame("post_rst_tx", 8'h01, 8'h01, 8'h20, 1, 8'h02, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
